queue_issue_sched: RTL
======================

# queue_issue_sched

Issue scheduler for the compacting multi-pop `queue`. Each cycle it picks up to `Ports` ready entries, oldest first (lowest index), from the queue's registered outputs. It drives the queue's per-entry pop vector and loads the picked entries into per-port output registers with a valid/ready handshake toward the consumers. It is the only block allowed to drive the queue's pop vector.

## Interface
Parameters:
- `Size`, 4: queue depth; must match the attached `queue`.
- `T`, `bit [3:0]`: entry type; must match the queue's `T`.
- `Ports`, 2: number of issue ports; 1 ≤ `Ports` ≤ `Size`.

Ports:
- `i_clk`  in  1  clock; all state updates on rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_flush`  in  1  discard in-flight issue state.
- `i_size`  in  `$clog2(Size+1)`  queue occupancy (queue `size` output).
- `i_entry`  in  `T [Size]`  queue contents; index 0 is oldest.
- `i_entry_ready`  in  `[Size]`  per-entry ready-to-issue flag from wakeup logic.
- `o_pop`  out  `[Size]`  pop vector to the queue; combinational.
- `o_valid`  out  `[Ports]`  issue port holds an entry.
- `o_data`  out  `T [Ports]`  issued entry per port.
- `i_ready`  in  `[Ports]`  consumer accepts port p this cycle.

## Operation
- Port p is *free* when `!o_valid[p] || i_ready[p]`. F is the number of free ports.
- Entry i is a *candidate* when `i < i_size && i_entry_ready[i]`. Entries at or beyond `i_size` are never candidates, regardless of `i_entry_ready`.
- Select the first `min(F, #candidates)` candidates in ascending index.
  - The k-th selected entry maps to the k-th free port, in ascending port index.
  - `o_pop[i]` = 1 exactly for the selected entries.
- At the clock edge:
  - A free port that was assigned loads the entry and sets `o_valid`.
  - A free port that was not assigned clears `o_valid`.
  - A non-free port holds `o_valid` and `o_data` unchanged.
- Flush: `o_pop` = 0 combinationally while `i_flush` = 1. At the next edge every `o_valid` clears. Handshakes completing in that cycle still count as consumed.
- The scheduler is stateless apart from the port registers. There is no FSM beyond the per-port EMPTY/FULL bit:
  - EMPTY → FULL on assign.
  - FULL → FULL on simultaneous consume and assign.
  - FULL → EMPTY on consume with no assign.
  - FULL holds while stalled.

## Timing
- Reset (async, `i_rst_n` = 0): `o_valid` = 0 and `o_data` = '0 immediately. `o_pop` = 0 combinationally while in reset.
- Latency: an entry that is ready and selected in cycle t appears on `o_valid`/`o_data` in cycle t+1. The queue removes it at the same edge.
- Throughput: up to `Ports` issues per cycle. A port can consume and reload in the same cycle, so there are no bubbles under continuous `i_ready`.
- `o_pop` depends only on current inputs and port state. No pop is issued for an entry that will not be captured at the same edge.
- Boundary cases:
  - Empty queue (`i_size` = 0): no pops.
  - All ports stalled: no pops, even if every entry is ready.
  - Reset asserted mid-stream: held entries are lost; the queue is reset by the same `i_rst_n`.

## Structure
- Shared package `issue_pkg`: port-index and occupancy width helper functions, plus the `Ports` default constant.
- Sub-module `oldest_ready_select`: combinational first-K picker.
  - Inputs: candidate vector and free-port vector.
  - Outputs: pop vector and, for each port, the assigned entry index plus an assign flag.
- Top level holds the port registers only.

## Test plan
Configuration: `Size`=4, `Ports`=2, `T` 4-bit. Entries are listed as `i_entry` {index 0, 1, 2, 3}.

- Reset: `i_rst_n`=0, `i_size`=4, all entries ready → `o_pop`=0000, `o_valid`=00. Release reset → normal operation resumes next cycle.
- Basic issue: entries {0,2,4,6}, all ready, `i_size`=4, `i_ready`=11 → `o_pop` bits 0 and 1 set. Next cycle port0=0, port1=2, both valid.
- Non-contiguous ready: entries {0,2,4,6}, ready only at indices 1 and 3 → pops indices 1 and 3. Next cycle port0=2, port1=6.
- Backpressure:
  - Setup: port1 holds 5 with `i_ready[1]`=0; port0 valid with `i_ready[0]`=1; entries {7,9}, both ready, `i_size`=2.
  - Response: only index 0 is popped. Next cycle port0=7 and port1 still holds 5.
- Size bound: `i_size`=2, ready at indices 2 and 3 only → `o_pop`=0000 and ports drain to invalid.
- Flush and async reset:
  - `i_flush`=1 with both ports valid and ready entries present → `o_pop`=0000; next cycle `o_valid`=00.
  - Separately, drop `i_rst_n` between edges with ports valid → `o_valid`=00 before the next edge.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared helpers for the issue scheduler: index/occupancy widths and the
// default number of issue ports.
package issue_pkg;

  localparam int PORTS_DEFAULT = 32'sd2;

  // Width needed to index n entries; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  // Width needed to hold an occupancy count from 0 to n inclusive.
  function automatic int occ_width(input int n);
    return $clog2(n + 32'sd1);
  endfunction

endpackage

// File: rtl/queue_issue_sched_select.sv
// Combinational first-K picker: walks the free ports in ascending order and
// hands each one the oldest candidate entry not yet taken by a lower port.
module oldest_ready_select
  import issue_pkg::*;
#(
  parameter int Size  = 32'sd4,
  parameter int Ports = PORTS_DEFAULT,
  localparam int IdxW = idx_width(Size)
) (
  input  logic [Size-1:0]  cand,
  input  logic [Ports-1:0] free,
  output logic [Size-1:0]  pop,
  output logic [IdxW-1:0]  port_idx [Ports],
  output logic [Ports-1:0] port_assign
);

  logic [Size-1:0] taken_s;
  logic            found_s;
  logic            pick_s;

  // Priority walk: ports in ascending index, entries oldest first; each
  // entry can be claimed by at most one port.
  always_comb begin
    taken_s     = '0;
    found_s     = 1'b0;
    pick_s      = 1'b0;
    port_assign = '0;
    for (int p = 0; p < Ports; p++) begin
      port_idx[p] = '0;
    end
    for (int p = 0; p < Ports; p++) begin
      found_s = 1'b0;
      if (free[p]) begin
        for (int i = 0; i < Size; i++) begin
          pick_s      = !found_s && cand[i] && !taken_s[i];
          taken_s[i]  = taken_s[i] | pick_s;
          found_s     = found_s | pick_s;
          // At most one pick per port, so OR-accumulating the index is exact.
          port_idx[p] = port_idx[p] | ({IdxW{pick_s}} & IdxW'(i));
        end
        port_assign[p] = found_s;
      end else begin
        port_assign[p] = 1'b0;
      end
    end
    pop = taken_s;
  end

endmodule

// File: rtl/queue_issue_sched.sv
// Issue scheduler for the compacting multi-pop queue. Picks up to Ports ready
// entries per cycle (oldest first), pops them from the queue and captures them
// into per-port output registers with a valid/ready handshake.
module queue_issue_sched
  import issue_pkg::*;
#(
  parameter int  Size  = 32'sd4,
  parameter type T     = logic [3:0],
  parameter int  Ports = PORTS_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_flush,
  input  logic [occ_width(Size)-1:0]  i_size,
  input  T                            i_entry [Size],
  input  logic [Size-1:0]             i_entry_ready,
  output logic [Size-1:0]             o_pop,
  output logic [Ports-1:0]            o_valid,
  output T                            o_data [Ports],
  input  logic [Ports-1:0]            i_ready
);

  localparam int OccW = occ_width(Size);
  localparam int IdxW = idx_width(Size);

  logic [Size-1:0]  cand_s;
  logic [Ports-1:0] free_s;
  logic [Size-1:0]  pop_s;
  logic [IdxW-1:0]  idx_s [Ports];
  logic [Ports-1:0] assign_s;

  // Candidates: ready entries inside the occupied region; nothing is offered
  // during flush or reset so the queue never loses an uncaptured entry.
  always_comb begin
    cand_s = '0;
    for (int i = 0; i < Size; i++) begin
      if ((OccW'(i) < i_size) && i_entry_ready[i] && !i_flush && i_rst_n) begin
        cand_s[i] = 1'b1;
      end else begin
        cand_s[i] = 1'b0;
      end
    end
  end

  // A port can take a new entry when empty or when its entry leaves this cycle.
  always_comb begin
    free_s = ~o_valid | i_ready;
  end

  oldest_ready_select #(
    .Size  (Size),
    .Ports (Ports)
  ) u_select (
    .cand        (cand_s),
    .free        (free_s),
    .pop         (pop_s),
    .port_idx    (idx_s),
    .port_assign (assign_s)
  );

  assign o_pop = pop_s;

  // Per-port EMPTY/FULL registers: load on assign, drain on consume, hold on stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= '0;
      for (int p = 0; p < Ports; p++) begin
        o_data[p] <= '0;
      end
    end else if (i_flush) begin
      o_valid <= '0;
    end else begin
      for (int p = 0; p < Ports; p++) begin
        if (free_s[p]) begin
          o_valid[p] <= assign_s[p];
          if (assign_s[p]) begin
            o_data[p] <= i_entry[idx_s[p]];
          end
        end
      end
    end
  end

endmodule
